uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit buffer and launch controller feeding `uart_tx`. It accepts bytes from the system side on a single-cycle write strobe and stores them in a circular FIFO. It presents one byte at a time to `uart_tx` via a one-cycle `tx_start` pulse plus a stable `din`, then waits for `tx_done_tick` before launching the next byte. This decouples producers (ALU result path, command responder) from the serial bit rate.

## Interface
- `DBIT`, 8: data word width; must match `uart_tx`.
- `ADDR_BITS`, 4: FIFO address width; depth = 2**ADDR_BITS (16).
- `clk`  in  1  system clock, same as `uart_tx`.
- `reset`  in  1  reset, active-low, asynchronous (one clock; reset is asynchronous and active-low).
- `wr`  in  1  write strobe; one byte per cycle while high.
- `w_data`  in  DBIT  byte to enqueue, sampled when `wr`=1.
- `clr_ovf`  in  1  synchronous clear of `overflow`.
- `tx_done_tick`  in  1  from `uart_tx`: stop bit finished.
- `tx_start`  out  1  to `uart_tx`: one-cycle launch pulse.
- `din`  out  DBIT  to `uart_tx`: byte being launched, registered.
- `full`  out  1  FIFO holds 2**ADDR_BITS entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_BITS+1  current occupancy, 0..2**ADDR_BITS.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- Storage: register array, `w_ptr`/`r_ptr` of ADDR_BITS, wrapping modulo depth; `count` is a separate ADDR_BITS+1 counter.
- Write accepted iff `wr` and (not `full` or pop this cycle). Accepted write stores at `w_ptr`, increments `w_ptr`.
- Write while `full` with no pop: data dropped, pointers unchanged, `overflow` set.
- Pop = `tx_done_tick` while in WAIT: increment `r_ptr`.
- `count_next = count + accepted_write - pop`; simultaneous write and pop leaves `count` unchanged.
- Launch FSM, states IDLE, START, WAIT:
  - IDLE: if not `empty`, go to START and register `din <= mem[r_ptr]`. Otherwise stay.
  - START: `tx_start`=1 (Moore, this state only). Unconditionally go to WAIT.
  - WAIT: hold `din`. On `tx_done_tick`, pop and go to IDLE.
- The entry stays in the FIFO until its `tx_done_tick`. `count` includes the byte on the line.
- `tx_done_tick` in IDLE or START is ignored; there is no pop.
- `overflow` is cleared by `clr_ovf` or reset. A set and a clear in the same cycle leaves it set.

## Timing
- Reset values: `tx_start`=0, `din`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, FSM=IDLE, pointers 0. Reset mid-transfer discards all contents. The shared reset also aborts `uart_tx`.
- Write latency: a write at edge E0 makes `empty`=0 and `count`=1 after E0.
- Launch: FSM enters START at E1, so `tx_start`=1 and `din` is valid in the cycle after E1. `tx_start` drops after E2.
- `din` is stable from START through WAIT until the pop edge.
- After `tx_done_tick`, the next byte's `tx_start` follows 2 cycles later: IDLE, then START.
- Throughput is bounded by `uart_tx`. The FIFO accepts a write on every cycle.
- Flags are registered/derived from `count` and are valid the cycle after the causing edge.

## Structure
- Shared package `uart_pkg`: FSM state encodings (IDLE/START/WAIT, 2 bits) and default `DBIT`. The package is shared with `uart_tx`/`uart_rx`.
- One sub-module, `fifo_regfile`:
  - parameterised DBIT/ADDR_BITS, synchronous write and asynchronous read.
  - instantiated for storage.
- Pointers, count and the FSM live in `uart_tx_fifo`.

## Test plan
- Reset, then write 0x55 once:
  - `tx_start` pulses exactly 1 cycle, 2 edges after the write, with `din`=0x55.
  - no further pulse until `tx_done_tick`.
- Write 0x01,0x02,0x03 back-to-back, with `tx_done_tick` 20 cycles after each launch:
  - three launches in order 0x01, 0x02, 0x03.
  - `count` goes 3→2→1→0 at each tick, then `empty`=1.
- Write 17 bytes 0x00..0x10 with no tick:
  - `full`=1 after the 16th.
  - 0x10 is dropped and `overflow`=1.
  - draining yields 0x00..0x0F; `clr_ovf` clears `overflow`.
- With FIFO full, assert `wr`(0xAA) in the same cycle as `tx_done_tick`:
  - the write is accepted, `count` stays 16, `overflow` stays 0.
  - 0xAA is launched last.
- Spurious `tx_done_tick` in IDLE with an empty FIFO:
  - no pop, `count`=0, `r_ptr` unchanged.
- Write 0x3C, assert `reset`=0 during WAIT:
  - all outputs go to reset values asynchronously.
  - after release there is no `tx_start` and `empty`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: launch FSM state encoding and default data width.
// Used by uart_tx_fifo today; uart_tx / uart_rx import the same encodings.
// Contents: DBIT_DEFAULT, tx_state_e (IDLE/START/WAIT, 2 bits).
package uart_pkg;

   localparam int DBIT_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the transmit FIFO: synchronous write, asynchronous read.
// Latency: write visible on r_data the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner decides when wr_en may be asserted.
// Ports: clk, wr_en/w_addr/w_data (write side), r_addr/r_data (read side).
module fifo_regfile #(
   parameter int DBIT      = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] w_addr,
   input  logic [DBIT-1:0]      w_data,
   input  logic [ADDR_BITS-1:0] r_addr,
   output logic [DBIT-1:0]      r_data
);

   logic [DBIT-1:0] mem_q [2**ADDR_BITS];

   // Contents need no reset: occupancy is tracked by the owner's counter.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[w_addr] <= w_data;
      end
   end

   assign r_data = mem_q[r_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer + launch controller in front of uart_tx (circular FIFO, 2**ADDR_BITS deep).
// Latency: write at E0 -> tx_start high after E1; next launch 2 cycles after tx_done_tick.
// Backpressure: none upstream; writes while full (without a pop) are dropped and flag overflow.
// Ports: clk, reset (async, active-low), wr/w_data/clr_ovf from system side,
//        tx_done_tick from uart_tx, tx_start/din to uart_tx, full/empty/count/overflow status.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DBIT      = DBIT_DEFAULT,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [DBIT-1:0]      w_data,
   input  logic                 clr_ovf,
   input  logic                 tx_done_tick,
   output logic                 tx_start,
   output logic [DBIT-1:0]      din,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow
);

   localparam int                 DEPTH     = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

   tx_state_e              state_q;
   logic                   tx_start_q;
   logic [DBIT-1:0]        din_q;
   logic [ADDR_BITS-1:0]   w_ptr_q, w_ptr_d;
   logic [ADDR_BITS-1:0]   r_ptr_q, r_ptr_d;
   logic [ADDR_BITS:0]     count_q, count_d;
   logic                   ovf_q, ovf_d;

   logic                   pop;
   logic                   wr_acc;
   logic [DBIT-1:0]        rd_data;

   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);

   // The head entry leaves only when its stop bit is done, so count includes the byte on the line.
   assign pop    = (state_q == WAIT) && tx_done_tick;
   // A pop frees the head slot this cycle, so a full FIFO can still take a write alongside it.
   assign wr_acc = wr && (!full || pop);

   fifo_regfile #(
      .DBIT      (DBIT),
      .ADDR_BITS (ADDR_BITS)
   ) u_regfile (
      .clk    (clk),
      .wr_en  (wr_acc),
      .w_addr (w_ptr_q),
      .w_data (w_data),
      .r_addr (r_ptr_q),
      .r_data (rd_data)
   );

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (wr_acc) w_ptr_d = w_ptr_q + ADDR_BITS'(1);
      if (pop)    r_ptr_d = r_ptr_q + ADDR_BITS'(1);
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
         2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
         default: count_d = count_q;
      endcase
      // Set has priority over clear so a drop in the clear cycle is never lost.
      if (wr && !wr_acc) ovf_d = 1'b1;
      else if (clr_ovf)  ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Launch FSM; tx_start and din are registered so uart_tx sees glitch-free inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         din_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  state_q    <= START;
                  tx_start_q <= 1'b1;
                  din_q      <= rd_data;
               end
            end
            START: begin
               state_q    <= WAIT;
               tx_start_q <= 1'b0;
            end
            WAIT: begin
               if (tx_done_tick) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               tx_start_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign din      = din_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model of the buffer.
// Summary: CHECKS <n> ERRORS <n>.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr;
   logic [7:0] w_data;
   logic       clr_ovf;
   logic       tx_done_tick;
   logic       tx_start;
   logic [7:0] din;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of buffered bytes, a "byte on the line" flag, a
   // "launch pulse showing now" flag, the last launched byte and the sticky flag.
   logic [7:0] mq[$];
   bit         m_busy;
   bit         m_start;
   bit         m_ovf;
   logic [7:0] m_din;
   logic [7:0] seen[$];

   always #5 clk = ~clk;

   uart_tx_fifo #(.DBIT(8), .ADDR_BITS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .w_data       (w_data),
      .clr_ovf      (clr_ovf),
      .tx_done_tick (tx_done_tick),
      .tx_start     (tx_start),
      .din          (din),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow)
   );

   task automatic model_reset();
      mq.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_ovf   = 1'b0;
      m_din   = 8'h00;
   endtask

   // Apply one cycle of inputs, advance the model by the same edge, sample #1 after it.
   task automatic cyc(input bit w, input logic [7:0] d, input bit t, input bit c);
      bit launch, pop, acc;
      logic [7:0] tmp;
      wr = w; w_data = d; tx_done_tick = t; clr_ovf = c;
      launch = !m_busy && (mq.size() != 0);
      pop    = t && m_busy && !m_start;
      acc    = w && ((mq.size() < 16) || pop);
      if (w && !acc) m_ovf = 1'b1;
      else if (c)    m_ovf = 1'b0;
      if (launch) begin
         m_din  = mq[0];
         m_busy = 1'b1;
      end
      if (pop) begin
         tmp    = mq.pop_front();
         m_busy = 1'b0;
      end
      m_start = launch;
      if (acc) mq.push_back(d);
      @(posedge clk);
      #1;
      wr = 1'b0; tx_done_tick = 1'b0; clr_ovf = 1'b0;
      if (tx_start === 1'b1) seen.push_back(din);
   endtask

   // Tick every cycle until the model queue empties; ticks outside WAIT are harmless.
   task automatic drain();
      for (int i = 0; i < 400 && mq.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0; wr = 1'b0; w_data = 8'h00; clr_ovf = 1'b0; tx_done_tick = 1'b0;
      model_reset();
      #12;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
      checks++; if (din !== 8'h00)     begin errors++; $display("FAIL reset_din got %h want 00", din); end
      checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single();
      seen.delete();
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_no_start_e0 got %b want 0", tx_start); end
      checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count got %0d want 1", count); end
      checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL single_empty got %b want 0", empty); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_e1 got %b want 1", tx_start); end
      checks++; if (din !== 8'h55)     begin errors++; $display("FAIL single_din got %h want 55", din); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", tx_start); end
      repeat (10) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (seen.size() != 1)  begin errors++; $display("FAIL single_pulse_count got %0d want 1", seen.size()); end
      checks++; if (din !== 8'h55)     begin errors++; $display("FAIL single_din_hold got %h want 55", din); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL single_pop_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_pop_empty got %b want 1", empty); end
   endtask

   task automatic test_back_to_back();
      int since = -1;
      int nt    = 0;
      bit t;
      seen.delete();
      for (int i = 0; i < 300 && nt < 3; i++) begin
         t = (since == 20);
         cyc(i < 3, 8'(i + 1), t, 1'b0);
         if (t) begin
            nt++;
            checks++;
            if (count !== 5'(3 - nt)) begin errors++; $display("FAIL b2b_count_after_tick%0d got %0d want %0d", nt, count, 3 - nt); end
         end
         if (tx_start === 1'b1) since = 0;
         else if (since >= 0) since++;
      end
      checks++; if (nt != 3)          begin errors++; $display("FAIL b2b_timeout ticks got %0d want 3", nt); end
      checks++; if (seen.size() != 3) begin errors++; $display("FAIL b2b_launches got %0d want 3", seen.size()); end
      for (int k = 0; k < 3 && k < seen.size(); k++) begin
         checks++;
         if (seen[k] !== 8'(k + 1)) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", k, seen[k], 8'(k + 1)); end
      end
      checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
   endtask

   task automatic test_overflow();
      seen.delete();
      for (int i = 0; i < 17; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 14) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_at15 got %b want 0", full); end end
         if (i == 15) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at16 got %b want 1", full); end end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
      drain();
      checks++; if (seen.size() != 16) begin errors++; $display("FAIL ovf_drain_len got %0d want 16", seen.size()); end
      for (int k = 0; k < 16 && k < seen.size(); k++) begin
         checks++;
         if (seen[k] !== 8'(k)) begin errors++; $display("FAIL ovf_drain[%0d] got %h want %h", k, seen[k], 8'(k)); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_full_simul();
      seen.delete();
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (full !== 1'b1)     begin errors++; $display("FAIL simul_full_before got %b want 1", full); end
      cyc(1'b1, 8'hAA, 1'b1, 1'b0);
      checks++; if (count !== 5'd16)   begin errors++; $display("FAIL simul_count got %0d want 16", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %b want 0", overflow); end
      drain();
      checks++; if (seen.size() != 17) begin errors++; $display("FAIL simul_len got %0d want 17", seen.size()); end
      for (int k = 0; k < 16 && k < seen.size(); k++) begin
         checks++;
         if (seen[k] !== 8'(8'h80 + k)) begin errors++; $display("FAIL simul_order[%0d] got %h want %h", k, seen[k], 8'(8'h80 + k)); end
      end
      if (seen.size() == 17) begin
         checks++;
         if (seen[16] !== 8'hAA) begin errors++; $display("FAIL simul_last got %h want aa", seen[16]); end
      end
   endtask

   task automatic test_spurious();
      seen.delete();
      repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL spur_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL spur_empty got %b want 1", empty); end
      checks++; if (seen.size() != 0)  begin errors++; $display("FAIL spur_launch got %0d want 0", seen.size()); end
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);   // tick on the launching edge (IDLE)
      cyc(1'b0, 8'h00, 1'b1, 1'b0);   // tick while the launch pulse is up (START)
      checks++; if (count !== 5'd1)    begin errors++; $display("FAIL spur_start_tick_count got %0d want 1", count); end
      checks++; if (seen.size() != 1 || seen[0] !== 8'h5A) begin errors++; $display("FAIL spur_rptr launches %0d first %h want 1 5a", seen.size(), din); end
      drain();
   endtask

   task automatic test_random();
      bit w, t, c;
      for (int i = 0; i < 3000; i++) begin
         if (i < 1500) begin
            w = ($urandom_range(1) == 0);
            t = ($urandom_range(7) == 0);
         end else begin
            w = ($urandom_range(7) == 0);
            t = ($urandom_range(1) == 0);
         end
         c = ($urandom_range(31) == 0);
         cyc(w, 8'($urandom), t, c);
         checks++; if (tx_start !== m_start)     begin errors++; $display("FAIL rnd_tx_start cyc %0d got %b want %b", i, tx_start, m_start); end
         checks++; if (din !== m_din)            begin errors++; $display("FAIL rnd_din cyc %0d got %h want %h", i, din, m_din); end
         checks++; if (count !== 5'(mq.size()))  begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); end
         checks++; if (full !== (mq.size() == 16)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", i, full, mq.size() == 16); end
         checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b want %b", i, empty, mq.size() == 0); end
         checks++; if (overflow !== m_ovf)       begin errors++; $display("FAIL rnd_overflow cyc %0d got %b want %b", i, overflow, m_ovf); end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);   // launcher now waiting for the stop bit
      checks++; if (din !== 8'h3C)     begin errors++; $display("FAIL rstmid_pre_din got %h want 3c", din); end
      #2 reset = 1'b0;
      #1;
      model_reset();
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start got %b want 0", tx_start); end
      checks++; if (din !== 8'h00)     begin errors++; $display("FAIL rstmid_din got %h want 00", din); end
      checks++; if (count !== 5'd0)    begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rstmid_full got %b want 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
      @(negedge clk);
      reset = 1'b1;
      seen.delete();
      repeat (6) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (seen.size() != 0)  begin errors++; $display("FAIL rstmid_no_start got %0d want 0", seen.size()); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rstmid_empty_after got %b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_simul();
      test_spurious();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
